inst_mem: RTL and testbench

//   Instruction memory responder on the fetch side of the CPU.

---
 rtl/inst_mem_if.sv | 46 ++++
 rtl/inst_mem.sv | 143 ++++++++++++++
 tb/tb_inst_mem.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/inst_mem_if.sv
// Fetch and loader signal bundle for the instruction memory.
// master: PC stage / host side; slave: the memory itself.
interface inst_mem_if;
  logic        ce;
  logic [31:0] addr;
  logic [31:0] inst;
  logic        inst_valid;
  logic        addr_err;
  logic        ld_start;
  logic        ld_byte_valid;
  logic [7:0]  ld_byte;
  logic        ld_last;
  logic        busy;
  logic        ld_done;
  logic        ld_ovf;

  modport master (
    output ce,
    output addr,
    output ld_start,
    output ld_byte_valid,
    output ld_byte,
    output ld_last,
    input  inst,
    input  inst_valid,
    input  addr_err,
    input  busy,
    input  ld_done,
    input  ld_ovf
  );

  modport slave (
    input  ce,
    input  addr,
    input  ld_start,
    input  ld_byte_valid,
    input  ld_byte,
    input  ld_last,
    output inst,
    output inst_valid,
    output addr_err,
    output busy,
    output ld_done,
    output ld_ovf
  );
endinterface

// File: rtl/inst_mem.sv
// Instruction memory with one-cycle registered fetch and a byte-serial loader
// that fills the array (big-endian within each word) while fetches are blocked.
module inst_mem #(
  parameter int unsigned ADDR_W   = 10,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input logic       clk,
  input logic       rst_n,
  inst_mem_if.slave bus
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PtrOne = 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       shift_q, shift_d;
  logic              ovf_q, ovf_d;

  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_q [Depth];
  logic [31:0]       rd_data_q;

  logic              inst_valid_q, inst_valid_d;
  logic              addr_err_q, addr_err_d;

  logic [31:0]       lane_word;
  logic [31:0]       merged_word;
  logic              addr_ok;
  logic [ADDR_W-1:0] fetch_idx;

  // First byte of a word lands in [31:24], the fourth in [7:0].
  assign lane_word   = {24'h0, bus.ld_byte} << {(2'd3 - bcnt_q), 3'b000};
  assign merged_word = shift_q | lane_word;

  assign addr_ok   = (bus.addr[1:0] == 2'b00) && ((bus.addr >> (ADDR_W + 2)) == 32'd0);
  assign fetch_idx = bus.addr[ADDR_W+1:2];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    bcnt_d    = bcnt_q;
    shift_d   = shift_q;
    ovf_d     = ovf_q;
    mem_we    = 1'b0;
    mem_wdata = merged_word;
    case (state_q)
      StIdle: begin
        if (bus.ld_start) begin
          state_d = StLoad;
          ptr_d   = '0;
          bcnt_d  = 2'd0;
          shift_d = 32'h0;
          ovf_d   = 1'b0;
        end
      end
      StLoad: begin
        if (bus.ld_byte_valid) begin
          if ((bcnt_q == 2'd3) || bus.ld_last) begin
            // Partial words on ld_last are committed with unfilled lanes left at zero.
            mem_we  = 1'b1;
            ptr_d   = ptr_q + PtrOne;
            bcnt_d  = 2'd0;
            shift_d = 32'h0;
            if (&ptr_q) begin
              ovf_d = 1'b1;
            end
            if (bus.ld_last) begin
              state_d = StDone;
            end
          end else begin
            shift_d = merged_word;
            bcnt_d  = bcnt_q + 2'd1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      bcnt_q  <= 2'd0;
      shift_q <= 32'h0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      ovf_q   <= ovf_d;
    end
  end

  // Fetch is only served in idle, so writes and reads never share a cycle.
  always_comb begin
    inst_valid_d = 1'b0;
    addr_err_d   = 1'b0;
    if ((state_q == StIdle) && bus.ce) begin
      inst_valid_d = 1'b1;
      addr_err_d   = ~addr_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      inst_valid_q <= inst_valid_d;
      addr_err_q   <= addr_err_d;
    end
  end

  // Array and read register carry no reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[ptr_q] <= mem_wdata;
    end
    rd_data_q <= mem_q[fetch_idx];
  end

  assign bus.inst       = (inst_valid_q && !addr_err_q) ? rd_data_q : NOP_INST;
  assign bus.inst_valid = inst_valid_q;
  assign bus.addr_err   = addr_err_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.ld_done    = (state_q == StDone);
  assign bus.ld_ovf     = ovf_q;

endmodule

// File: tb/tb_inst_mem.sv
// Randomized self-checking bench for inst_mem against a word/byte-level reference model.
module tb_inst_mem;

  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  inst_mem_if bus_if ();

  inst_mem #(
    .ADDR_W  (AW),
    .NOP_INST(NOP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] model_mem   [DEPTH];
  bit          model_known [DEPTH];
  bit          model_ovf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.ce            = 1'b0;
    bus_if.addr          = 32'h0;
    bus_if.ld_start      = 1'b0;
    bus_if.ld_byte_valid = 1'b0;
    bus_if.ld_byte       = 8'h00;
    bus_if.ld_last       = 1'b0;
  endtask

  // Words are consecutive 4-byte groups, big-endian, stored modulo DEPTH.
  task automatic apply_model(input byte_q_t b, input bit keep_partial);
    int n  = b.size();
    int nw = keep_partial ? (n + 3) / 4 : n / 4;
    for (int w = 0; w < nw; w++) begin
      logic [31:0] word = 32'h0;
      for (int k = 0; k < 4; k++) begin
        if (4 * w + k < n) word[31 - 8 * k -: 8] = b[4 * w + k];
      end
      model_mem[w % DEPTH]   = word;
      model_known[w % DEPTH] = 1'b1;
    end
    model_ovf = keep_partial && (nw >= DEPTH);
  endtask

  task automatic check_fetch(input logic [31:0] a, input int hold);
    bit ok  = (a % 4 == 0) && ((a >> (AW + 2)) == 0);
    int idx = int'((a >> 2) % DEPTH);
    bus_if.ce   = 1'b1;
    bus_if.addr = a;
    for (int h = 0; h < hold; h++) begin
      tick();
      check_eq("fetch_valid", 32'(bus_if.inst_valid), 32'd1);
      check_eq("fetch_err", 32'(bus_if.addr_err), 32'(!ok));
      if (!ok) check_eq("fetch_err_inst", bus_if.inst, NOP);
      else if (model_known[idx]) check_eq("fetch_inst", bus_if.inst, model_mem[idx]);
    end
    bus_if.ce = 1'b0;
    tick();
    check_eq("noce_valid", 32'(bus_if.inst_valid), 32'd0);
    check_eq("noce_err", 32'(bus_if.addr_err), 32'd0);
    check_eq("noce_inst", bus_if.inst, NOP);
  endtask

  task automatic do_load(input byte_q_t b);
    int n = b.size();
    idle_inputs();
    bus_if.ld_start = 1'b1;
    tick();
    bus_if.ld_start = 1'b0;
    check_eq("ld_busy_start", 32'(bus_if.busy), 32'd1);
    check_eq("ld_ovf_clear", 32'(bus_if.ld_ovf), 32'd0);
    for (int i = 0; i < n; i++) begin
      int gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        // Stray last/start/ce while no byte is valid must all be ignored.
        bus_if.ld_byte_valid = 1'b0;
        bus_if.ld_last       = 1'($urandom_range(0, 1));
        bus_if.ld_start      = 1'($urandom_range(0, 1));
        bus_if.ce            = 1'($urandom_range(0, 1));
        bus_if.addr          = 32'h0;
        tick();
        check_eq("gap_busy", 32'(bus_if.busy), 32'd1);
        check_eq("gap_valid", 32'(bus_if.inst_valid), 32'd0);
        check_eq("gap_done", 32'(bus_if.ld_done), 32'd0);
      end
      bus_if.ld_start      = 1'b0;
      bus_if.ce            = 1'b0;
      bus_if.ld_byte_valid = 1'b1;
      bus_if.ld_byte       = b[i];
      bus_if.ld_last       = (i == n - 1);
      tick();
      check_eq("byte_busy", 32'(bus_if.busy), 32'd1);
      check_eq("byte_done", 32'(bus_if.ld_done), 32'(i == n - 1));
    end
    idle_inputs();
    tick();
    check_eq("post_done", 32'(bus_if.ld_done), 32'd0);
    check_eq("post_busy", 32'(bus_if.busy), 32'd0);
    apply_model(b, 1'b1);
    check_eq("ld_ovf", 32'(bus_if.ld_ovf), 32'(model_ovf));
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0, 1:    return 32'($urandom_range(0, DEPTH - 1)) * 4;
      2:       return (32'($urandom_range(0, DEPTH - 1)) * 4) | 32'($urandom_range(1, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    byte_q_t b;
    idle_inputs();

    // Reset with a fetch pending: outputs stay quiet until released.
    rst_n       = 1'b0;
    bus_if.ce   = 1'b1;
    bus_if.addr = 32'h0;
    tick();
    check_eq("rst_inst", bus_if.inst, NOP);
    check_eq("rst_valid", 32'(bus_if.inst_valid), 32'd0);
    check_eq("rst_err", 32'(bus_if.addr_err), 32'd0);
    check_eq("rst_busy", 32'(bus_if.busy), 32'd0);
    check_eq("rst_done", 32'(bus_if.ld_done), 32'd0);
    check_eq("rst_ovf", 32'(bus_if.ld_ovf), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("first_valid", 32'(bus_if.inst_valid), 32'd1);
    check_eq("first_err", 32'(bus_if.addr_err), 32'd0);
    idle_inputs();
    tick();

    b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_load(b);
    check_fetch(32'h0, 1);
    check_fetch(32'h4, 2);

    b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    do_load(b);
    check_fetch(32'h4, 1);
    check_fetch(32'h0, 1);

    check_fetch(32'h2, 1);
    check_fetch(32'(4 * DEPTH), 1);
    check_fetch(32'h8000_0000, 1);

    // Twenty bytes into a four-word array wraps once.
    b = {};
    for (int i = 0; i < 20; i++) b.push_back(8'($urandom));
    do_load(b);
    check_eq("wrap_ovf", 32'(bus_if.ld_ovf), 32'd1);
    for (int w = 0; w < DEPTH; w++) check_fetch(32'(w * 4), 1);

    // Reset after six bytes: only the completed first word is retained.
    b = {};
    for (int i = 0; i < 6; i++) b.push_back(8'($urandom));
    bus_if.ld_start = 1'b1;
    tick();
    bus_if.ld_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus_if.ld_byte_valid = 1'b1;
      bus_if.ld_byte       = b[i];
      tick();
    end
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("midrst_busy", 32'(bus_if.busy), 32'd0);
    check_eq("midrst_ovf", 32'(bus_if.ld_ovf), 32'd0);
    check_eq("midrst_done", 32'(bus_if.ld_done), 32'd0);
    apply_model(b, 1'b0);
    tick();
    check_fetch(32'h0, 1);
    check_fetch(32'h4, 1);

    for (int r = 0; r < 8; r++) begin
      int n = $urandom_range(1, 20);
      b = {};
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      do_load(b);
      for (int f = 0; f < 12; f++) check_fetch(rand_addr(), $urandom_range(1, 2));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
